// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding, prescale constants and widths for the UART receiver
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5
    } rx_state_t;

    localparam int PS_W   = 6;
    localparam int BIT_W  = 4;
    localparam int DATA_W = 8;

    localparam logic [PS_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PS_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PS_W-1:0] PRESCALE_32 = 6'd32;

    // Anything outside the legal set falls back to 8 so the edge counter always wraps.
    function automatic logic [PS_W-1:0] legal_prescale(input logic [PS_W-1:0] p);
        return (p == PRESCALE_16 || p == PRESCALE_32) ? p : PRESCALE_8;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversample edge counter and bit counter for the UART receiver
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [PS_W-1:0]  prescale,
    output logic [PS_W-1:0]  edge_cnt,
    output logic [BIT_W-1:0] bit_cnt
);

    // edge_cnt wraps at prescale-1 and advances bit_cnt; clear holds both at zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable) begin
            if (edge_cnt == prescale - 6'd1) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive control FSM issuing sampling, check and shift strobes
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic [PS_W-1:0]  prescale,
    input  logic             strt_glitch,
    input  logic             par_err,
    input  logic             stp_err,
    output logic             dat_samp_en,
    output logic [PS_W-1:0]  edge_cnt,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             strt_chk_en,
    output logic             par_chk_en,
    output logic             stp_chk_en,
    output logic             deser_en,
    output logic             data_valid
);

    rx_state_t       state, next_state;
    logic [PS_W-1:0] ps_q;
    logic            par_en_q;
    logic            armed;
    logic            in_frame;
    logic            last;
    logic            pre_last;
    logic            start_ok;

    assign in_frame = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    assign last     = edge_cnt == ps_q - 6'd1;
    assign pre_last = edge_cnt == ps_q - 6'd2;
    // A start is taken from CHECK on a low line, or from IDLE once the line has been seen high since reset.
    assign start_ok = !RX_IN && ((state == CHECK) || (state == IDLE && armed));

    uart_rx_edge_bit_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .enable   (in_frame),
        .clear    (!in_frame),
        .prescale (ps_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt)
    );

    // State register plus frame-accept pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data_valid <= 1'b0;
        end else begin
            state      <= next_state;
            data_valid <= (state == CHECK) && !((par_err && par_en_q) || stp_err);
        end
    end

    // Frame configuration is captured only when a frame starts; armed waits for an idle-high line after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q     <= PRESCALE_8;
            par_en_q <= 1'b0;
            armed    <= 1'b0;
        end else begin
            armed <= armed || RX_IN;
            if (start_ok) begin
                ps_q     <= legal_prescale(prescale);
                par_en_q <= PAR_EN;
            end
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start_ok ? START : IDLE;
            START:   next_state = last ? (strt_glitch ? IDLE : DATA) : START;
            DATA:    next_state = (last && bit_cnt == 4'(DATA_W)) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  next_state = last ? STOP : PARITY;
            STOP:    next_state = last ? CHECK : STOP;
            CHECK:   next_state = start_ok ? START : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes decoded from registered state and counters
    always_comb begin
        dat_samp_en = in_frame;
        strt_chk_en = (state == START) && pre_last;
        deser_en    = (state == DATA) && last;
        par_chk_en  = (state == PARITY) && last;
        stp_chk_en  = (state == STOP) && pre_last;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: table-driven frame checks plus mid-frame reset sequence for uart_rx_fsm
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
    logic [5:0] prescale;
    logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int c_samp, c_deser, c_strt, c_par, c_stp, c_dv, max_e;

    typedef struct {
        logic [5:0]  ps;
        logic        pe;
        logic [31:0] seq;
        int          len;
        int          glen;
        logic        perr;
        logic        serr;
        logic        sg;
        logic [5:0]  mid_ps;
        int          e_samp;
        int          e_deser;
        int          e_strt;
        int          e_par;
        int          e_stp;
        int          e_dv;
        int          e_gap;
    } vec_t;

    vec_t tv[8];

    always #5 clk = ~clk;

    uart_rx_fsm dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .prescale    (prescale),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid)
    );

    function automatic logic [31:0] frame(input logic [7:0] d, input logic pe);
        return {11'h7FF, 10'h3FF, 1'b1, pe ? ^d : 1'b1, d, 1'b0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int i, input vec_t v);
        int  zeros, first_on, last_on, fall, dv_at;
        bit  seen;
        prescale    = v.ps;
        PAR_EN      = v.pe;
        par_err     = v.perr;
        stp_err     = v.serr;
        strt_glitch = v.sg;
        c_samp = 0; c_deser = 0; c_strt = 0; c_par = 0; c_stp = 0; c_dv = 0; max_e = 0;
        zeros = 0; first_on = -1; last_on = -1; fall = -1; dv_at = -1; seen = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (dat_samp_en) begin
                c_samp++;
                if (!seen) first_on = n;
                seen    = 1;
                last_on = n;
                zeros   = 0;
            end else if (seen) begin
                zeros++;
                if (fall < 0) fall = n;
            end
            c_deser += int'(deser_en);
            c_strt  += int'(strt_chk_en);
            c_par   += int'(par_chk_en);
            c_stp   += int'(stp_chk_en);
            c_dv    += int'(data_valid);
            if (data_valid && dv_at < 0) dv_at = n;
            if (int'(edge_cnt) > max_e) max_e = int'(edge_cnt);
            if (n == 20 && v.mid_ps != 6'd0) begin
                prescale = v.mid_ps;
                PAR_EN   = !v.pe;
            end
            if (v.glen > 0) RX_IN = (n >= v.glen);
            else if (n < v.len * int'(v.ps)) RX_IN = v.seq[n / int'(v.ps)];
            else RX_IN = 1'b1;
            if (zeros >= 4) break;
        end
        chk($sformatf("r%0d_finished", i), int'(zeros >= 4), 1);
        chk($sformatf("r%0d_samp_cycles", i), c_samp, v.e_samp);
        chk($sformatf("r%0d_deser_en", i), c_deser, v.e_deser);
        chk($sformatf("r%0d_strt_chk_en", i), c_strt, v.e_strt);
        chk($sformatf("r%0d_par_chk_en", i), c_par, v.e_par);
        chk($sformatf("r%0d_stp_chk_en", i), c_stp, v.e_stp);
        chk($sformatf("r%0d_data_valid", i), c_dv, v.e_dv);
        chk($sformatf("r%0d_gap", i), last_on - first_on + 1 - c_samp, v.e_gap);
        chk($sformatf("r%0d_max_edge", i), max_e, int'(v.ps) - 1);
        if (v.e_dv > 0) chk($sformatf("r%0d_dv_latency", i), dv_at - fall, 1);
        chk($sformatf("r%0d_idle_after", i), int'(dat_samp_en), 0);
    endtask

    initial begin
        logic [31:0] s1, s2, s;
        int          quiet, got;
        rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_samp", int'(dat_samp_en), 0);
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_bit_cnt", int'(bit_cnt), 0);
        chk("rst_strobes", int'({strt_chk_en, par_chk_en, stp_chk_en, deser_en}), 0);
        chk("rst_data_valid", int'(data_valid), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_samp", int'(dat_samp_en), 0);

        s1 = frame(8'h3C, 1'b0);
        s2 = frame(8'hC3, 1'b0);
        //        ps     pe    seq                        len glen perr  serr  sg    mid    samp des st pa sp dv gap
        tv[0] = '{6'd8,  1'b0, frame(8'h55, 1'b0),        10, 0,   1'b0, 1'b0, 1'b0, 6'd32, 80,  8,  1, 0, 1, 1, 0};
        tv[1] = '{6'd16, 1'b1, frame(8'hA3, 1'b1),        11, 0,   1'b1, 1'b0, 1'b0, 6'd0,  176, 8,  1, 1, 1, 0, 0};
        tv[2] = '{6'd32, 1'b0, 32'hFFFFFFFF,              0,  10,  1'b0, 1'b0, 1'b1, 6'd0,  32,  0,  1, 0, 0, 0, 0};
        tv[3] = '{6'd16, 1'b0, frame(8'h0F, 1'b0),        10, 0,   1'b1, 1'b0, 1'b0, 6'd0,  160, 8,  1, 0, 1, 1, 0};
        tv[4] = '{6'd32, 1'b1, frame(8'h00, 1'b1),        11, 0,   1'b0, 1'b1, 1'b0, 6'd0,  352, 8,  1, 1, 1, 0, 0};
        tv[5] = '{6'd8,  1'b1, frame(8'hFF, 1'b1),        11, 0,   1'b0, 1'b0, 1'b0, 6'd0,  88,  8,  1, 1, 1, 1, 0};
        tv[6] = '{6'd8,  1'b0, {s2[21:0], s1[9:0]},       20, 0,   1'b0, 1'b0, 1'b0, 6'd0,  160, 16, 2, 0, 2, 2, 1};
        tv[7] = '{6'd8,  1'b0, 32'h00000000,              11, 0,   1'b0, 1'b1, 1'b0, 6'd0,  160, 16, 2, 0, 2, 0, 1};
        for (int i = 0; i < 8; i++) run(i, tv[i]);

        prescale = 6'd8; PAR_EN = 1'b0; par_err = 1'b0; stp_err = 1'b0; strt_glitch = 1'b0;
        s = frame(8'h55, 1'b0);
        for (int n = 0; n <= 34; n++) begin
            @(negedge clk);
            if (n == 34) begin
                chk("pre_rst_bit_cnt", int'(bit_cnt), 4);
                chk("pre_rst_edge_cnt", int'(edge_cnt), 1);
                chk("pre_rst_samp", int'(dat_samp_en), 1);
            end
            RX_IN = s[n / 8];
        end
        rst   = 1'b1;
        RX_IN = 1'b0;
        @(negedge clk);
        chk("mid_rst_samp", int'(dat_samp_en), 0);
        chk("mid_rst_edge_cnt", int'(edge_cnt), 0);
        chk("mid_rst_bit_cnt", int'(bit_cnt), 0);
        chk("mid_rst_strobes", int'({strt_chk_en, par_chk_en, stp_chk_en, deser_en}), 0);
        chk("mid_rst_data_valid", int'(data_valid), 0);
        rst   = 1'b0;
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            quiet += int'(dat_samp_en) + int'(data_valid);
        end
        chk("low_after_rst_ignored", quiet, 0);
        RX_IN = 1'b1;
        @(negedge clk);
        RX_IN = 1'b0;
        got = 0;
        for (int n = 0; n < 4 && got == 0; n++) begin
            @(negedge clk);
            got = int'(dat_samp_en);
        end
        chk("new_edge_starts", got, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: none; prescale is a run-time input.
REQ-002 clk  in  1  single block clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 RX_IN  in  1  serial line, idle high, already synchronised.
REQ-005 PAR_EN  in  1  1 = frame carries a parity bit.
REQ-006 prescale  in  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 strt_glitch  in  1  registered start-check result, 1 = false start.
REQ-008 par_err  in  1  registered parity-check result.
REQ-009 stp_err  in  1  registered stop-check result.
REQ-010 dat_samp_en  out  1  enables the bit sampler.
REQ-011 edge_cnt  out  6  oversample edge index within the current bit.
REQ-012 bit_cnt  out  4  bit index within the frame (0 = start bit).
REQ-013 strt_chk_en, par_chk_en, stp_chk_en  out  1 each  single-cycle check strobes.
REQ-014 deser_en  out  1  single-cycle shift strobe to the deserializer.
REQ-015 data_valid  out  1  single-cycle pulse, frame accepted.

Function
REQ-016 States: IDLE, START, DATA, PARITY, STOP, CHECK; the state register is binary-encoded.
REQ-017 edge_cnt counts 0..prescale-1 in every non-IDLE, non-CHECK state and wraps to 0.
- On wrap, bit_cnt increments.
- Both counters are held at 0 in IDLE and CHECK.
REQ-018 IDLE: RX_IN==0 -> START on the next edge; otherwise stay in IDLE.
REQ-019 START: strt_chk_en=1 when edge_cnt==prescale-2.
- At edge_cnt==prescale-1: strt_glitch=1 -> IDLE; otherwise -> DATA.
REQ-020 DATA: deser_en=1 when edge_cnt==prescale-1.
- When bit_cnt==8 and edge_cnt==prescale-1: -> PARITY if PAR_EN, else -> STOP.
REQ-021 PARITY: par_chk_en=1 when edge_cnt==prescale-1; -> STOP at the same point.
REQ-022 STOP: stp_chk_en=1 when edge_cnt==prescale-2.
- At edge_cnt==prescale-1: -> CHECK.
REQ-023 CHECK lasts exactly one cycle.
- data_valid is registered to 1 in the following cycle iff !(par_err|stp_err).
- par_err is masked to 0 when PAR_EN==0.
REQ-024 CHECK exit: RX_IN==0 -> START (back-to-back frame, no IDLE cycle); otherwise -> IDLE.
REQ-025 dat_samp_en=1 in START, DATA, PARITY and STOP; 0 otherwise.
REQ-026 All strobes are decoded from registered state and counters only; each strobe is high for exactly one cycle per bit.
REQ-027 prescale and PAR_EN are latched on the IDLE->START or CHECK->START transition; changes mid-frame have no effect.
REQ-028 An RX_IN low pulse shorter than half a bit is rejected via strt_glitch; no deser_en or data_valid is issued.
REQ-029 Line held low through STOP gives stp_err=1 and no data_valid; the FSM returns to IDLE or START per REQ-024.

Reset
REQ-030 rst=1 at any clock edge forces IDLE, including mid-frame.
- edge_cnt, bit_cnt = 0.
- All strobes and data_valid = 0.
- Latched prescale = 8; latched PAR_EN = 0.
REQ-031 Following reset release, the first frame is accepted only from a new falling edge seen in IDLE.

Structure
REQ-032 Shared package uart_rx_pkg holds:
- the state enumeration;
- legal prescale constants (8/16/32);
- the data width constant (8).
REQ-033 One sub-module, uart_rx_edge_bit_counter, holds edge_cnt/bit_cnt with inputs enable, clear and prescale; the FSM instantiates it.

Verification
REQ-034 Prescale 8, PAR_EN=0, frame 0x55, clean stop:
- exactly 8 deser_en pulses;
- data_valid=1 one cycle after CHECK;
- total 80 cycles from the falling edge to CHECK.
REQ-035 Prescale 16, PAR_EN=1, frame 0xA3 with even parity but par_err=1 forced:
- par_chk_en pulses once;
- data_valid stays 0;
- FSM returns to IDLE.
REQ-036 Prescale 32, low glitch of 10 cycles, strt_glitch=1:
- FSM returns START->IDLE at edge_cnt 31;
- zero deser_en pulses.
REQ-037 Two back-to-back frames, prescale 8, RX_IN=0 during CHECK:
- no IDLE cycle between frames;
- two data_valid pulses.
REQ-038 rst=1 asserted in DATA at bit_cnt=4:
- next cycle state IDLE, counters 0, all outputs 0;
- no data_valid for the aborted frame.
